// File: rtl/multi_channel_trigger_cell.sv
// Multi-channel registered gate cell: per channel, y = (a0&a1) & ~(b0&b1)
// through DEPTH flops, with valid tracking, saturating hit counters, sticky trig.
//
// Ports:
//   I1470_clk  rising-edge clock
//   I1477_rst  synchronous active-high reset
//   en         advance pipeline, fill counter, hit counters and trig
//   clr        synchronous soft clear, same effect as reset
//   a0,a1      set-path operands, bit c = channel c
//   b0,b1      mask-path operands, bit c = channel c
//   y          per-channel result from last-stage registers
//   valid      pipeline holds only post-clear data
//   hit_cnt    per-channel counters, channel c at [c*CNT_W +: CNT_W]
//   trig       sticky: some counter reached THRESH
module multi_channel_trigger_cell #(
   parameter int CH     = 4,
   parameter int DEPTH  = 1,
   parameter int CNT_W  = 8,
   parameter int THRESH = 3
) (
   input  logic                  I1470_clk,
   input  logic                  I1477_rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic [CH-1:0]         a0,
   input  logic [CH-1:0]         a1,
   input  logic [CH-1:0]         b0,
   input  logic [CH-1:0]         b1,
   output logic [CH-1:0]         y,
   output logic                  valid,
   output logic [CH*CNT_W-1:0]   hit_cnt,
   output logic                  trig
);

   localparam int FW = $clog2(DEPTH + 1);
   localparam logic [FW-1:0]    FILL_MAX = FW'(DEPTH);
   localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] SAT      = '1;

   logic [DEPTH-1:0][CH-1:0]    set_q, set_d;
   logic [DEPTH-1:0][CH-1:0]    mask_q, mask_d;
   logic [FW-1:0]               fill_q, fill_d;
   logic [CH-1:0][CNT_W-1:0]    cnt_q, cnt_d;
   logic                        trig_q, trig_d;

   assign y       = set_q[DEPTH-1] & ~mask_q[DEPTH-1];
   assign valid   = (fill_q == FILL_MAX);
   assign hit_cnt = cnt_q;
   assign trig    = trig_q;

   always_comb begin
      set_d  = set_q;
      mask_d = mask_q;
      fill_d = fill_q;
      cnt_d  = cnt_q;
      trig_d = trig_q;
      if (en) begin
         set_d[0]  = a0 & a1;
         mask_d[0] = b0 & b1;
         for (int k = 1; k < DEPTH; k++) begin
            set_d[k]  = set_q[k-1];
            mask_d[k] = mask_q[k-1];
         end
         if (!valid) begin
            fill_d = fill_q + 1'b1;
         end
         // y here is the pre-edge output, so a hit counts the value
         // being displayed when the edge arrives.
         for (int c = 0; c < CH; c++) begin
            if (valid && y[c] && (cnt_q[c] != SAT)) begin
               cnt_d[c] = cnt_q[c] + 1'b1;
            end
         end
         // Compare next-state counts so trig rises with the qualifying hit.
         for (int c = 0; c < CH; c++) begin
            if (cnt_d[c] >= THR) begin
               trig_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge I1470_clk) begin
      if (I1477_rst || clr) begin
         set_q  <= '0;
         mask_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
         trig_q <= 1'b0;
      end else begin
         set_q  <= set_d;
         mask_q <= mask_d;
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
         trig_q <= trig_d;
      end
   end

endmodule
